// File: rtl/dot_prod_peak_if.sv
// Product-in / peak-out bundle for dot_prod_peak.
// The peak2_mag member exists only when DOT_PROD_PEAK_SECOND_EN is defined.
interface dot_prod_peak_if #(
  parameter int i_bits   = 24,
  parameter int q_bits   = 24,
  parameter int mag_bits = 49,
  parameter int idx_bits = 4
);
  logic                       m_axis_product_tvalid;
  logic signed [i_bits-1:0]   i;
  logic signed [q_bits-1:0]   q;
  logic                       m_axis_peak_tready;
  logic                       s_axis_peak_tvalid;
  logic        [mag_bits-1:0] peak_mag;
  logic        [idx_bits-1:0] peak_idx;
  logic                       overflow;
`ifdef DOT_PROD_PEAK_SECOND_EN
  logic        [mag_bits-1:0] peak2_mag;

  modport slave (
    input  m_axis_product_tvalid, i, q, m_axis_peak_tready,
    output s_axis_peak_tvalid, peak_mag, peak_idx, overflow, peak2_mag
  );
  modport master (
    output m_axis_product_tvalid, i, q, m_axis_peak_tready,
    input  s_axis_peak_tvalid, peak_mag, peak_idx, overflow, peak2_mag
  );
`else
  modport slave (
    input  m_axis_product_tvalid, i, q, m_axis_peak_tready,
    output s_axis_peak_tvalid, peak_mag, peak_idx, overflow
  );
  modport master (
    output m_axis_product_tvalid, i, q, m_axis_peak_tready,
    input  s_axis_peak_tvalid, peak_mag, peak_idx, overflow
  );
`endif
endinterface

// File: rtl/dot_prod_peak.sv
// Frame-wise peak search over |i + jq|^2 of complex dot-product results.
// Optional second-largest magnitude output: define DOT_PROD_PEAK_SECOND_EN.
module dot_prod_peak #(
  parameter int i_bits   = 24,
  parameter int q_bits   = 24,
  parameter int length   = 16,
  parameter int mag_bits = 49,
  parameter int idx_bits = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  dot_prod_peak_if.slave     bus
);

  localparam int p_bits = 2 * ((i_bits > q_bits) ? i_bits : q_bits);
  localparam logic [idx_bits-1:0] last_idx = idx_bits'(length - 1);

  // S1: squares
  logic                     v1;
  logic [p_bits-1:0]        i_sq;
  logic [p_bits-1:0]        q_sq;
  logic signed [p_bits-1:0] i_ext;
  logic signed [p_bits-1:0] q_ext;

  // S2: magnitude
  logic                     v2;
  logic [mag_bits-1:0]      mag;

  // S3: running search
  logic [idx_bits-1:0]      cnt;
  logic [mag_bits-1:0]      run_max;
  logic [idx_bits-1:0]      run_idx;
  logic                     take_max;
  logic [mag_bits-1:0]      nxt_max;
  logic [idx_bits-1:0]      nxt_idx;
  logic                     close;
`ifdef DOT_PROD_PEAK_SECOND_EN
  logic [mag_bits-1:0]      run_2;
  logic [mag_bits-1:0]      nxt_2;
`endif

  assign i_ext = p_bits'(bus.i);
  assign q_ext = p_bits'(bus.q);

  // NOTE: every clocked block uses <= so all stages see pre-edge values and
  // the pipeline advances one stage per edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      i_sq <= '0;
      q_sq <= '0;
      v2   <= 1'b0;
      mag  <= '0;
    end else begin
      v1 <= bus.m_axis_product_tvalid;
      if (bus.m_axis_product_tvalid) begin
        i_sq <= i_ext * i_ext;
        q_sq <= q_ext * q_ext;
      end
      v2 <= v1;
      if (v1) mag <= mag_bits'(i_sq) + mag_bits'(q_sq);
    end
  end

  // NOTE: each always_comb output gets its value on every path, so no latch
  // can be inferred.
  always_comb begin
    take_max = (cnt == '0) || (mag > run_max);
    nxt_max  = take_max ? mag : run_max;
    nxt_idx  = take_max ? cnt : run_idx;
    close    = v2 && (cnt == last_idx);
`ifdef DOT_PROD_PEAK_SECOND_EN
    // A tie with the max lands here as mag > run_2 and becomes the second.
    nxt_2 = run_2;
    if (cnt == '0)             nxt_2 = '0;
    else if (mag > run_max)    nxt_2 = run_max;
    else if (mag > run_2)      nxt_2 = mag;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      run_max <= '0;
      run_idx <= '0;
`ifdef DOT_PROD_PEAK_SECOND_EN
      run_2   <= '0;
`endif
    end else if (v2) begin
      cnt     <= (cnt == last_idx) ? '0 : cnt + idx_bits'(1);
      run_max <= nxt_max;
      run_idx <= nxt_idx;
`ifdef DOT_PROD_PEAK_SECOND_EN
      run_2   <= nxt_2;
`endif
    end
  end

  // Result register: a closing frame always wins; overflow flags that the
  // result it replaces was never taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.s_axis_peak_tvalid <= 1'b0;
      bus.peak_mag           <= '0;
      bus.peak_idx           <= '0;
      bus.overflow           <= 1'b0;
`ifdef DOT_PROD_PEAK_SECOND_EN
      bus.peak2_mag          <= '0;
`endif
    end else if (close) begin
      bus.s_axis_peak_tvalid <= 1'b1;
      bus.peak_mag           <= nxt_max;
      bus.peak_idx           <= nxt_idx;
      bus.overflow           <= bus.s_axis_peak_tvalid && !bus.m_axis_peak_tready;
`ifdef DOT_PROD_PEAK_SECOND_EN
      bus.peak2_mag          <= nxt_2;
`endif
    end else if (bus.s_axis_peak_tvalid && bus.m_axis_peak_tready) begin
      bus.s_axis_peak_tvalid <= 1'b0;
      bus.overflow           <= 1'b0;
    end
  end

endmodule
